// File: rtl/calc_input_sequencer.sv
// Keypad operand/operator sequencer feeding the 4-bit adder/subtractor.
// Optional running-total chaining from DONE: define CALC_CHAIN_EN.
module calc_input_sequencer #(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   input  logic              op_add,
   input  logic              op_sub,
   input  logic              equals,
   input  logic              clear,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic              mode,
   input  logic [DATA_W-1:0] sum,
   input  logic              cout,
   input  logic              overflow,
   output logic [DATA_W-1:0] result,
   output logic              result_cout,
   output logic              result_ovf,
   output logic              result_valid,
   output logic              seq_err
);

   typedef enum logic [2:0] {
      S_A, S_OP, S_B, S_EQ, S_EXEC, S_DONE
   } state_t;

   state_t            state, state_d;
   logic [DATA_W-1:0] a_d, b_d, res_d;
   logic              mode_d, rc_d, ro_d, err_d;

   // One winning strobe per edge: clear > din > sub > add > equals
   logic w_dv, w_op, w_eq;
   assign w_dv = !clear && din_valid;
   assign w_op = !clear && !din_valid && (op_sub || op_add);
   assign w_eq = !clear && !din_valid && !op_sub && !op_add
                 && equals;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_A;
         a           <= '0;
         b           <= '0;
         mode        <= 1'b0;
         result      <= '0;
         result_cout <= 1'b0;
         result_ovf  <= 1'b0;
         seq_err     <= 1'b0;
      end else begin
         state       <= state_d;
         a           <= a_d;
         b           <= b_d;
         mode        <= mode_d;
         result      <= res_d;
         result_cout <= rc_d;
         result_ovf  <= ro_d;
         seq_err     <= err_d;
      end
   end

   always_comb begin
      state_d = state;
      a_d     = a;
      b_d     = b;
      mode_d  = mode;
      res_d   = result;
      rc_d    = result_cout;
      ro_d    = result_ovf;
      err_d   = 1'b0;
      if (clear) begin
         state_d = S_A;
         a_d     = '0;
         b_d     = '0;
         mode_d  = 1'b0;
      end else begin
         case (state)
            S_A: begin
               if (w_dv) begin
                  a_d     = din;
                  state_d = S_OP;
               end else if (w_op || w_eq) begin
                  err_d = 1'b1;
               end
            end
            S_OP: begin
               if (w_dv) begin
                  a_d = din;
               end else if (w_op) begin
                  mode_d  = op_sub;
                  state_d = S_B;
               end else if (w_eq) begin
                  err_d = 1'b1;
               end
            end
            S_B: begin
               if (w_dv) begin
                  b_d     = din;
                  state_d = S_EQ;
               end else if (w_op || w_eq) begin
                  err_d = 1'b1;
               end
            end
            S_EQ: begin
               if (w_dv) begin
                  b_d = din;
               end else if (w_eq) begin
                  state_d = S_EXEC;
               end else if (w_op) begin
                  err_d = 1'b1;
               end
            end
            S_EXEC: begin
               res_d   = sum;
               rc_d    = cout;
               ro_d    = overflow;
               state_d = S_DONE;
            end
            S_DONE: begin
               if (w_dv) begin
                  a_d     = din;
                  state_d = S_OP;
               end else if (w_op) begin
`ifdef CALC_CHAIN_EN
                  a_d     = result;
                  mode_d  = op_sub;
                  state_d = S_B;
`else
                  err_d = 1'b1;
`endif
               end else if (w_eq) begin
                  err_d = 1'b1;
               end
            end
            default: state_d = S_A;
         endcase
      end
   end

   assign result_valid = (state == S_DONE);

endmodule
